// File: rtl/dict_writer.sv
// dict_writer: builds the Forth dictionary key table one character at a time.
// Ports: i_clk/i_rst_n/i_clear, char valid/ready input, o_keys table, count/full,
// commit/drop pulses. Optional FORGET via macro DICT_WRITER_FORGET_EN (adds i_forget).
module dict_writer #(
  parameter int ENTRIES    = 2,
  parameter int KEY_WIDTH  = 8,
  parameter int KEY_LENGTH = 1,
  localparam int CW = $clog2(ENTRIES + 1),
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int EW = KEY_LENGTH * KEY_WIDTH,
  localparam int TW = ENTRIES * EW
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
`ifdef DICT_WRITER_FORGET_EN
  input  logic                 i_forget,
`endif
  input  logic                 i_char_valid,
  input  logic [KEY_WIDTH-1:0] i_char,
  input  logic                 i_char_last,
  output logic                 o_char_ready,
  output logic [TW-1:0]        o_keys,
  output logic [CW-1:0]        o_count,
  output logic                 o_full,
  output logic                 o_wr_done,
  output logic [IW-1:0]        o_wr_index,
  output logic                 o_err
);

  localparam int PW = $clog2(KEY_LENGTH + 1);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] DROP    = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [EW-1:0] staging;
  logic          xfer;

  assign o_char_ready = (state != COMMIT);
  assign xfer         = i_char_valid && o_char_ready;
  assign o_full       = (o_count == CW'(ENTRIES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_keys     <= '0;
      o_count    <= '0;
      o_wr_index <= '0;
      o_wr_done  <= 1'b0;
      o_err      <= 1'b0;
      state      <= COLLECT;
      ptr        <= '0;
      staging    <= '0;
    end else begin
      o_wr_done <= 1'b0;
      o_err     <= 1'b0;
      if (i_clear) begin
        o_keys     <= '0;
        o_count    <= '0;
        o_wr_index <= '0;
        state      <= COLLECT;
        ptr        <= '0;
        staging    <= '0;
      end else begin
        unique case (state)
          COLLECT: begin
            if (xfer) begin
              for (int j = 0; j < KEY_LENGTH; j++)
                if (ptr == PW'(j))
                  staging[j*KEY_WIDTH +: KEY_WIDTH] <= i_char;
              ptr <= ptr + PW'(1);
              if (i_char_last) begin
                if (o_full) begin
                  o_err   <= 1'b1;
                  staging <= '0;
                  ptr     <= '0;
                end else begin
                  state <= COMMIT;
                end
              end else if (ptr == PW'(KEY_LENGTH - 1)) begin
                state <= DROP;
              end
            end
          end
          DROP: begin
            if (xfer && i_char_last) begin
              o_err   <= 1'b1;
              staging <= '0;
              ptr     <= '0;
              state   <= COLLECT;
            end
          end
          COMMIT: begin
            for (int e = 0; e < ENTRIES; e++)
              if (o_count == CW'(e))
                o_keys[e*EW +: EW] <= staging;
            o_wr_index <= IW'(o_count);
            o_count    <= o_count + CW'(1);
            o_wr_done  <= 1'b1;
            staging    <= '0;
            ptr        <= '0;
            state      <= COLLECT;
          end
          default: state <= COLLECT;
        endcase
`ifdef DICT_WRITER_FORGET_EN
        // Later NBAs override the COLLECT branch's count/key updates;
        // the character itself is still latched into staging.
        if (i_forget && state == COLLECT && ptr == '0 && o_count != '0) begin
          for (int e = 0; e < ENTRIES; e++)
            if (o_count - CW'(1) == CW'(e))
              o_keys[e*EW +: EW] <= '0;
          o_count <= o_count - CW'(1);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_dict_writer.sv
// tb_dict_writer: directed self-checking bench for dict_writer
// (ENTRIES=4, KEY_WIDTH=8, KEY_LENGTH=4).
module tb_dict_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        forget;
  logic        valid;
  logic [7:0]  ch;
  logic        last;
  logic        ready;
  logic [127:0] keys;
  logic [2:0]  count;
  logic        full;
  logic        wr_done;
  logic [1:0]  wr_index;
  logic        err;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dict_writer #(.ENTRIES(4), .KEY_WIDTH(8), .KEY_LENGTH(4)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_clear(clear),
`ifdef DICT_WRITER_FORGET_EN
    .i_forget(forget),
`endif
    .i_char_valid(valid),
    .i_char(ch),
    .i_char_last(last),
    .o_char_ready(ready),
    .o_keys(keys),
    .o_count(count),
    .o_full(full),
    .o_wr_done(wr_done),
    .o_wr_index(wr_index),
    .o_err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c, input logic l);
    valid = 1'b1;
    ch = c;
    last = l;
    step();
    valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    tests++;
    if (keys !== '0 || count !== 3'd0 || wr_index !== 2'd0) begin
      failed++;
      $display("FAIL reset_state keys=%h count=%0d idx=%0d want 0", keys, count, wr_index);
    end
    tests++;
    if (wr_done !== 1'b0 || err !== 1'b0 || ready !== 1'b1 || full !== 1'b0) begin
      failed++;
      $display("FAIL reset_flags done=%b err=%b rdy=%b full=%b want 0,0,1,0",
               wr_done, err, ready, full);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    send_char(8'h44, 1'b0);
    send_char(8'h55, 1'b0);
    send_char(8'h50, 1'b1);
    tests++;
    if (ready !== 1'b0) begin
      failed++;
      $display("FAIL commit_ready got %b want 0", ready);
    end
    tests++;
    if (wr_done !== 1'b0 || count !== 3'd0) begin
      failed++;
      $display("FAIL commit_early done=%b count=%0d want 0,0", wr_done, count);
    end
    step();
    tests++;
    if (keys !== 128'h0000_0000_0000_0000_0000_0000_0050_5544) begin
      failed++;
      $display("FAIL single_entry got %h want entry0=00505544", keys);
    end
    tests++;
    if (wr_done !== 1'b1 || wr_index !== 2'd0 || count !== 3'd1) begin
      failed++;
      $display("FAIL single_flags done=%b idx=%0d count=%0d want 1,0,1",
               wr_done, wr_index, count);
    end
    step();
    tests++;
    if (wr_done !== 1'b0 || ready !== 1'b1) begin
      failed++;
      $display("FAIL single_pulse done=%b rdy=%b want 0,1", wr_done, ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] chars [10] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65,
                               8'h66, 8'h67, 8'h68, 8'h69, 8'h6a};
    logic       lasts [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int k = 0;
    int stalls = 0;
    int cyc = 0;
    logic r;
    do_clear();
    tests++;
    if (count !== 3'd0 || keys !== '0) begin
      failed++;
      $display("FAIL clear_basic count=%0d keys=%h want 0", count, keys);
    end
    valid = 1'b1;
    while (k < 10 && cyc < 50) begin
      ch = chars[k];
      last = lasts[k];
      r = ready;
      step();
      cyc++;
      if (r) k++;
      else stalls++;
    end
    valid = 1'b0;
    last = 1'b0;
    tests++;
    if (k !== 10 || stalls !== 3) begin
      failed++;
      $display("FAIL b2b_stalls sent=%0d stalls=%0d want 10,3", k, stalls);
    end
    tests++;
    if (ready !== 1'b0) begin
      failed++;
      $display("FAIL b2b_final_ready got %b want 0", ready);
    end
    step();
    tests++;
    if (count !== 3'd4 || full !== 1'b1 || wr_index !== 2'd3) begin
      failed++;
      $display("FAIL b2b_count count=%0d full=%b idx=%0d want 4,1,3",
               count, full, wr_index);
    end
    tests++;
    if (keys !== 128'h6a696867_00666564_00006362_00000061) begin
      failed++;
      $display("FAIL b2b_table got %h want 6a696867006665640000636200000061", keys);
    end
    send_char(8'h41, 1'b1);
    tests++;
    if (err !== 1'b1 || wr_done !== 1'b0 || ready !== 1'b1) begin
      failed++;
      $display("FAIL full_err err=%b done=%b rdy=%b want 1,0,1", err, wr_done, ready);
    end
    step();
    tests++;
    if (err !== 1'b0 || count !== 3'd4 ||
        keys !== 128'h6a696867_00666564_00006362_00000061) begin
      failed++;
      $display("FAIL full_unchanged err=%b count=%0d keys=%h want 0,4,same",
               err, count, keys);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    send_char(8'h41, 1'b1);
    step();
    send_char(8'h31, 1'b0);
    send_char(8'h32, 1'b0);
    send_char(8'h33, 1'b0);
    send_char(8'h34, 1'b0);
    tests++;
    if (err !== 1'b0 || ready !== 1'b1) begin
      failed++;
      $display("FAIL drop_early err=%b rdy=%b want 0,1", err, ready);
    end
    send_char(8'h35, 1'b1);
    tests++;
    if (err !== 1'b1 || count !== 3'd1 || wr_done !== 1'b0) begin
      failed++;
      $display("FAIL overflow_err err=%b count=%0d done=%b want 1,1,0",
               err, count, wr_done);
    end
    send_char(8'h58, 1'b1);
    step();
    tests++;
    if (wr_done !== 1'b1 || wr_index !== 2'd1 || count !== 3'd2 ||
        keys[63:0] !== 64'h00000058_00000041) begin
      failed++;
      $display("FAIL after_drop done=%b idx=%0d count=%0d keys=%h want 1,1,2,..58_..41",
               wr_done, wr_index, count, keys[63:0]);
    end
  endtask

  task automatic test_clear_commit();
    send_char(8'h5a, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    tests++;
    if (count !== 3'd0 || keys !== '0 || wr_done !== 1'b0 || wr_index !== 2'd0) begin
      failed++;
      $display("FAIL clear_commit count=%0d keys=%h done=%b idx=%0d want 0",
               count, keys, wr_done, wr_index);
    end
    valid = 1'b1;
    ch = 8'h77;
    last = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    valid = 1'b0;
    last = 1'b0;
    tests++;
    if (ready !== 1'b1 || err !== 1'b0) begin
      failed++;
      $display("FAIL clear_char rdy=%b err=%b want 1,0", ready, err);
    end
    step();
    tests++;
    if (count !== 3'd0 || wr_done !== 1'b0) begin
      failed++;
      $display("FAIL clear_char_late count=%0d done=%b want 0,0", count, wr_done);
    end
  endtask

  task automatic test_async_reset();
    send_char(8'h51, 1'b1);
    step();
    send_char(8'h52, 1'b1);
    step();
    send_char(8'h11, 1'b0);
    send_char(8'h22, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (count !== 3'd0 || keys !== '0 || wr_index !== 2'd0) begin
      failed++;
      $display("FAIL async_reset count=%0d keys=%h idx=%0d want 0",
               count, keys, wr_index);
    end
    step();
    rst_n = 1'b1;
    step();
    send_char(8'h41, 1'b0);
    send_char(8'h42, 1'b1);
    step();
    tests++;
    if (keys !== 128'h0000_4241 || wr_index !== 2'd0 || count !== 3'd1) begin
      failed++;
      $display("FAIL reset_resume keys=%h idx=%0d count=%0d want ..00004241,0,1",
               keys, wr_index, count);
    end
  endtask

`ifdef DICT_WRITER_FORGET_EN
  task automatic test_forget();
    do_clear();
    send_char(8'h41, 1'b1);
    step();
    send_char(8'h42, 1'b1);
    step();
    forget = 1'b1;
    step();
    forget = 1'b0;
    tests++;
    if (count !== 3'd1 || keys !== 128'h0000_0041) begin
      failed++;
      $display("FAIL forget count=%0d keys=%h want 1,..41", count, keys);
    end
    send_char(8'h43, 1'b0);
    forget = 1'b1;
    step();
    forget = 1'b0;
    tests++;
    if (count !== 3'd1) begin
      failed++;
      $display("FAIL forget_mid count=%0d want 1", count);
    end
    send_char(8'h44, 1'b1);
    step();
    tests++;
    if (count !== 3'd2 || keys[63:32] !== 32'h00004443) begin
      failed++;
      $display("FAIL forget_resume count=%0d e1=%h want 2,00004443",
               count, keys[63:32]);
    end
  endtask
`endif

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    forget = 1'b0;
    valid = 1'b0;
    ch = 8'h00;
    last = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_clear_commit();
    test_async_reset();
`ifdef DICT_WRITER_FORGET_EN
    test_forget();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
